// File: rtl/fetch_unit.sv
// Instruction fetch / decode-register stage for the 8-bit CPU.
// Holds the PC, drives a 1-cycle-latency instruction memory, registers the
// returned word into split fields, resolves JMP/BZ and stops on HALT.
module fetch_unit #(
    parameter int unsigned     PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = 8'h00,
    parameter logic [3:0]      OP_BZ    = 4'hD,
    parameter logic [3:0]      OP_JMP   = 4'hE,
    parameter logic [3:0]      OP_HALT  = 4'hF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            zero_flag,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_rd,
    input  logic [15:0]     imem_data,
    output logic            instr_vld,
    output logic [3:0]      Op,
    output logic [1:0]      Rs,
    output logic [1:0]      Rt,
    output logic [1:0]      Rd,
    output logic [7:0]      imm,
    output logic [PC_W-1:0] pc_out,
    output logic            halted
);

    typedef enum logic {StRun, StHalted} state_e;

    state_e          state_q;
    logic [PC_W-1:0] pc_q;
    logic            epoch_q;
    // Tag of the read issued last cycle: valid, epoch at issue, address.
    logic            fl_vld_q;
    logic            fl_epoch_q;
    logic [PC_W-1:0] fl_pc_q;
    // One-entry skid for a word that arrives while the decode register is stalled.
    logic            skid_vld_q;
    logic [15:0]     skid_data_q;
    logic [PC_W-1:0] skid_pc_q;
    logic [15:0]     ir_q;

    logic arrive;
    logic consume;
    logic take;
    logic do_halt;

    assign imem_addr = pc_q;
    assign Op        = ir_q[15:12];
    assign Rs        = ir_q[11:10];
    assign Rt        = ir_q[9:8];
    assign Rd        = ir_q[7:6];
    assign imm       = ir_q[7:0];

    // Read strobe, live-word detection and branch/halt resolution.
    always_comb begin
        imem_rd = (state_q == StRun) & ~stall & ~skid_vld_q;
        // A word from a read issued before a flush carries a stale epoch.
        arrive  = fl_vld_q & (fl_epoch_q == epoch_q) & (state_q == StRun);
        consume = instr_vld & ~stall;
        take    = consume & ((Op == OP_JMP) | ((Op == OP_BZ) & zero_flag));
        do_halt = consume & (Op == OP_HALT);
    end

    // PC, in-flight tag, skid, decode register and run/halt state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StRun;
            pc_q        <= RESET_PC;
            epoch_q     <= 1'b0;
            fl_vld_q    <= 1'b0;
            fl_epoch_q  <= 1'b0;
            fl_pc_q     <= '0;
            skid_vld_q  <= 1'b0;
            skid_data_q <= '0;
            skid_pc_q   <= '0;
            ir_q        <= '0;
            instr_vld   <= 1'b0;
            pc_out      <= '0;
            halted      <= 1'b0;
        end else begin
            fl_vld_q   <= imem_rd;
            fl_epoch_q <= epoch_q;
            fl_pc_q    <= pc_q;

            if (take) begin
                pc_q    <= PC_W'(imm);
                epoch_q <= ~epoch_q;
            end else if (imem_rd) begin
                pc_q <= pc_q + PC_W'(1);
            end

            if (state_q == StHalted) begin
                instr_vld <= 1'b0;
            end else if (do_halt) begin
                state_q    <= StHalted;
                halted     <= 1'b1;
                instr_vld  <= 1'b0;
                skid_vld_q <= 1'b0;
            end else if (take) begin
                // The word arriving now belongs to the fall-through path.
                instr_vld  <= 1'b0;
                skid_vld_q <= 1'b0;
            end else if (stall) begin
                if (arrive) begin
                    skid_vld_q  <= 1'b1;
                    skid_data_q <= imem_data;
                    skid_pc_q   <= fl_pc_q;
                end
            end else if (skid_vld_q) begin
                ir_q        <= skid_data_q;
                pc_out      <= skid_pc_q;
                instr_vld   <= 1'b1;
                skid_vld_q  <= arrive;
                skid_data_q <= imem_data;
                skid_pc_q   <= fl_pc_q;
            end else begin
                instr_vld <= arrive;
                if (arrive) begin
                    ir_q   <= imem_data;
                    pc_out <= fl_pc_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes the expected consumed
// instructions, monitors pop and compare on every consumption.
`timescale 1ns/1ps
module tb_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] w;
    } exp_t;

    // Instance A: RESET_PC = 0
    logic        rst_na, stall_a, zero_a, rd_a, vld_a, halted_a;
    logic [7:0]  addr_a, imm_a, pcout_a;
    logic [15:0] data_a;
    logic [3:0]  op_a;
    logic [1:0]  rs_a, rt_a, rdf_a;
    logic [15:0] mem_a [256];

    // Instance B: RESET_PC = FE
    logic        rst_nb, stall_b, zero_b, rd_b, vld_b, halted_b;
    logic [7:0]  addr_b, imm_b, pcout_b;
    logic [15:0] data_b;
    logic [3:0]  op_b;
    logic [1:0]  rs_b, rt_b, rdf_b;
    logic [15:0] mem_b [256];

    fetch_unit dut_a (
        .clk(clk), .rst_n(rst_na), .stall(stall_a), .zero_flag(zero_a),
        .imem_addr(addr_a), .imem_rd(rd_a), .imem_data(data_a),
        .instr_vld(vld_a), .Op(op_a), .Rs(rs_a), .Rt(rt_a), .Rd(rdf_a), .imm(imm_a),
        .pc_out(pcout_a), .halted(halted_a)
    );

    fetch_unit #(.RESET_PC(8'hFE)) dut_b (
        .clk(clk), .rst_n(rst_nb), .stall(stall_b), .zero_flag(zero_b),
        .imem_addr(addr_b), .imem_rd(rd_b), .imem_data(data_b),
        .instr_vld(vld_b), .Op(op_b), .Rs(rs_b), .Rt(rt_b), .Rd(rdf_b), .imm(imm_b),
        .pc_out(pcout_b), .halted(halted_b)
    );

    // Synchronous instruction memories, one-cycle read latency.
    always @(posedge clk) begin
        if (rd_a) data_a <= mem_a[addr_a];
        if (rd_b) data_b <= mem_b[addr_b];
    end

    int   n_pass = 0;
    int   n_total = 0;
    int   cur = 0;
    exp_t exp_a[$];
    exp_t exp_b[$];
    logic halt_seen_a = 1'b0;
    logic halt_seen_b = 1'b0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    endtask

    // Monitor A: check every consumed instruction against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_na) begin
            halt_seen_a = 1'b0;
        end else begin
            if (halt_seen_a) begin
                cmp("A halted after HALT", 32'(halted_a), 32'd1);
                cmp("A vld after HALT", 32'(vld_a), 32'd0);
                halt_seen_a = 1'b0;
            end
            if (vld_a && !stall_a) begin
                if (exp_a.size() == 0) begin
                    cmp("A unexpected instr pc", 32'(pcout_a), 32'h100);
                end else begin
                    e = exp_a.pop_front();
                    cmp("A pc", 32'(pcout_a), 32'(e.pc));
                    cmp("A fields", 32'({op_a, rs_a, rt_a, rdf_a, imm_a}),
                        32'({e.w[15:12], e.w[11:10], e.w[9:8], e.w[7:6], e.w[7:0]}));
                end
                if (op_a == 4'hF) halt_seen_a = 1'b1;
            end
        end
    end

    // Monitor B: same checks for the wrap-around instance.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_nb) begin
            halt_seen_b = 1'b0;
        end else begin
            if (halt_seen_b) begin
                cmp("B halted after HALT", 32'(halted_b), 32'd1);
                cmp("B vld after HALT", 32'(vld_b), 32'd0);
                halt_seen_b = 1'b0;
            end
            if (vld_b && !stall_b) begin
                if (exp_b.size() == 0) begin
                    cmp("B unexpected instr pc", 32'(pcout_b), 32'h100);
                end else begin
                    e = exp_b.pop_front();
                    cmp("B pc", 32'(pcout_b), 32'(e.pc));
                    cmp("B fields", 32'({op_b, rs_b, rt_b, rdf_b, imm_b}),
                        32'({e.w[15:12], e.w[11:10], e.w[9:8], e.w[7:6], e.w[7:0]}));
                end
                if (op_b == 4'hF) halt_seen_b = 1'b1;
            end
        end
    end

    // Cycle k = k-th cycle after reset release; positioned 1ns after its rising edge.
    task automatic to_cycle(input int k);
        repeat (k - cur) @(posedge clk);
        #1;
        cur = k;
    endtask

    // Move to the middle of cycle k for sampling.
    task automatic at(input int k);
        to_cycle(k);
        #5;
    endtask

    task automatic push_a(input logic [7:0] pc, input logic [15:0] w);
        exp_t e;
        e.pc = pc;
        e.w  = w;
        exp_a.push_back(e);
    endtask

    task automatic start_a(input logic z);
        rst_na  = 1'b0;
        stall_a = 1'b0;
        zero_a  = z;
        repeat (2) @(posedge clk);
        #1;
        cmp("A reset vld", 32'(vld_a), 32'd0);
        cmp("A reset pc_out", 32'(pcout_a), 32'd0);
        cmp("A reset halted", 32'(halted_a), 32'd0);
        cmp("A reset addr", 32'(addr_a), 32'd0);
        rst_na = 1'b1;
        cur    = 0;
    endtask

    task automatic wait_halt_a(input string name);
        int i = 0;
        while (!halted_a && i < 40) begin
            @(posedge clk);
            #1;
            i++;
        end
        cmp(name, 32'(halted_a), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        cmp("A rd after halt", 32'(rd_a), 32'd0);
        cmp("A queue drained", exp_a.size(), 32'd0);
    endtask

    task automatic clr_mem_a();
        foreach (mem_a[i]) mem_a[i] = 16'h0000;
    endtask

    task automatic load_jmp_prog();
        clr_mem_a();
        mem_a[0] = 16'h1100; mem_a[1] = 16'h2240; mem_a[2] = 16'hE005;
        mem_a[3] = 16'h3380; mem_a[5] = 16'h1234; mem_a[6] = 16'hF000;
    endtask

    task automatic push_jmp_exp();
        push_a(8'd0, 16'h1100); push_a(8'd1, 16'h2240); push_a(8'd2, 16'hE005);
        push_a(8'd5, 16'h1234); push_a(8'd6, 16'hF000);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_na = 1'b0; stall_a = 1'b0; zero_a = 1'b0;
        rst_nb = 1'b0; stall_b = 1'b0; zero_b = 1'b0;
        foreach (mem_b[i]) mem_b[i] = 16'h0000;

        // 1. straight line
        clr_mem_a();
        mem_a[0] = 16'h1100; mem_a[1] = 16'h2240; mem_a[2] = 16'h3380;
        mem_a[3] = 16'h1000; mem_a[4] = 16'hF000;
        push_a(8'd0, 16'h1100); push_a(8'd1, 16'h2240); push_a(8'd2, 16'h3380);
        push_a(8'd3, 16'h1000); push_a(8'd4, 16'hF000);
        start_a(1'b0);
        at(0); cmp("T1 vld cycle0", 32'(vld_a), 32'd0);
        at(1); cmp("T1 vld cycle1", 32'(vld_a), 32'd0);
        for (int k = 2; k <= 6; k++) begin
            at(k);
            cmp("T1 vld streaming", 32'(vld_a), 32'd1);
            cmp("T1 pc_out streaming", 32'(pcout_a), 32'(k - 2));
        end
        wait_halt_a("T1 halt reached");

        // 2. JMP
        load_jmp_prog();
        push_jmp_exp();
        start_a(1'b0);
        at(4); cmp("T2 pc_out jmp", 32'(pcout_a), 32'd2);
        at(5); cmp("T2 bubble1", 32'(vld_a), 32'd0);
        at(6); cmp("T2 bubble2", 32'(vld_a), 32'd0);
        at(7);
        cmp("T2 target vld", 32'(vld_a), 32'd1);
        cmp("T2 target pc", 32'(pcout_a), 32'd5);
        cmp("T2 target Op", 32'(op_a), 32'd1);
        cmp("T2 target Rs", 32'(rs_a), 32'd0);
        cmp("T2 target Rt", 32'(rt_a), 32'd2);
        cmp("T2 target imm", 32'(imm_a), 32'h34);
        wait_halt_a("T2 halt reached");

        // 3a. BZ not taken
        clr_mem_a();
        mem_a[0] = 16'h1100; mem_a[1] = 16'hD007; mem_a[2] = 16'h2240;
        mem_a[3] = 16'hF000; mem_a[7] = 16'h3380; mem_a[8] = 16'hF000;
        push_a(8'd0, 16'h1100); push_a(8'd1, 16'hD007); push_a(8'd2, 16'h2240);
        push_a(8'd3, 16'hF000);
        start_a(1'b0);
        at(3); cmp("T3a pc_out bz", 32'(pcout_a), 32'd1);
        at(4);
        cmp("T3a no bubble vld", 32'(vld_a), 32'd1);
        cmp("T3a no bubble pc", 32'(pcout_a), 32'd2);
        wait_halt_a("T3a halt reached");

        // 3b. BZ taken
        push_a(8'd0, 16'h1100); push_a(8'd1, 16'hD007); push_a(8'd7, 16'h3380);
        push_a(8'd8, 16'hF000);
        start_a(1'b1);
        at(3); cmp("T3b pc_out bz", 32'(pcout_a), 32'd1);
        at(4); cmp("T3b bubble1", 32'(vld_a), 32'd0);
        at(5); cmp("T3b bubble2", 32'(vld_a), 32'd0);
        at(6);
        cmp("T3b target vld", 32'(vld_a), 32'd1);
        cmp("T3b target pc", 32'(pcout_a), 32'd7);
        wait_halt_a("T3b halt reached");

        // 4. stall for 3 cycles while pc_out = 4
        clr_mem_a();
        mem_a[0] = 16'h1100; mem_a[1] = 16'h2240; mem_a[2] = 16'h3380;
        mem_a[3] = 16'h1000; mem_a[4] = 16'h1104; mem_a[5] = 16'h2208;
        mem_a[6] = 16'hF000;
        push_a(8'd0, 16'h1100); push_a(8'd1, 16'h2240); push_a(8'd2, 16'h3380);
        push_a(8'd3, 16'h1000); push_a(8'd4, 16'h1104); push_a(8'd5, 16'h2208);
        push_a(8'd6, 16'hF000);
        start_a(1'b0);
        to_cycle(6);
        stall_a = 1'b1;
        at(6); cmp("T4 held pc c6", 32'(pcout_a), 32'd4);
        at(7);
        cmp("T4 rd off c7", 32'(rd_a), 32'd0);
        cmp("T4 held pc c7", 32'(pcout_a), 32'd4);
        at(8);
        cmp("T4 rd off c8", 32'(rd_a), 32'd0);
        cmp("T4 held fields c8", 32'({op_a, imm_a}), 32'h104);
        to_cycle(9);
        stall_a = 1'b0;
        at(10);
        cmp("T4 release vld", 32'(vld_a), 32'd1);
        cmp("T4 release pc", 32'(pcout_a), 32'd5);
        wait_halt_a("T4 halt reached");

        // 5. PC wrap and HALT on instance B
        mem_b[8'hFE] = 16'h2240; mem_b[8'hFF] = 16'h3380; mem_b[8'h00] = 16'hF000;
        begin
            exp_t e;
            e.pc = 8'hFE; e.w = 16'h2240; exp_b.push_back(e);
            e.pc = 8'hFF; e.w = 16'h3380; exp_b.push_back(e);
            e.pc = 8'h00; e.w = 16'hF000; exp_b.push_back(e);
        end
        repeat (2) @(posedge clk);
        #1;
        cmp("B reset addr", 32'(addr_b), 32'hFE);
        cmp("B reset pc_out", 32'(pcout_b), 32'd0);
        rst_nb = 1'b1;
        cur    = 0;
        at(2); cmp("T5 pc FE", 32'(pcout_b), 32'hFE);
        at(3); cmp("T5 pc FF", 32'(pcout_b), 32'hFF);
        at(4); cmp("T5 pc 00", 32'(pcout_b), 32'h00);
        at(5); cmp("T5 halted", 32'(halted_b), 32'd1);
        for (int k = 6; k <= 9; k++) begin
            at(k);
            cmp("T5 rd after halt", 32'(rd_b), 32'd0);
        end
        cmp("B queue drained", exp_b.size(), 32'd0);

        // 6. reset during a taken branch
        load_jmp_prog();
        push_jmp_exp();
        start_a(1'b0);
        to_cycle(4);
        #2;
        rst_na = 1'b0;
        #1;
        cmp("T6 async vld", 32'(vld_a), 32'd0);
        cmp("T6 async pc_out", 32'(pcout_a), 32'd0);
        cmp("T6 async fields", 32'({op_a, imm_a}), 32'd0);
        cmp("T6 async addr", 32'(addr_a), 32'd0);
        exp_a.delete();
        push_jmp_exp();
        @(posedge clk);
        #1;
        rst_na = 1'b1;
        cur    = 0;
        at(1); cmp("T6 no stale vld", 32'(vld_a), 32'd0);
        at(2);
        cmp("T6 restart vld", 32'(vld_a), 32'd1);
        cmp("T6 restart pc", 32'(pcout_a), 32'd0);
        at(7); cmp("T6 target pc", 32'(pcout_a), 32'd5);
        wait_halt_a("T6 halt reached");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
